seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Sequential signed integer divider; the inverse operation of the team's 16-bit signed add/sub block.
- Uses one shared WIDTH-bit trial subtractor, iterated once per clock (restoring algorithm).
- Sits beside the add/sub datapath on the lab boards.
- Produces quotient, remainder, an overflow flag and a divide-by-zero flag, with a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width in bits, two's complement; legal range 4..32.

Ports:
- Clock  input  1  rising-edge clock, the only clock.
- Resetn  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  signed numerator; captured on the accepting edge.
- divisor  input  WIDTH  signed denominator; captured on the accepting edge.
- busy  output  1  high from the accepting edge until done falls.
- done  output  1  one-cycle pulse; results valid from this cycle onward.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder, same sign as dividend (or zero).
- overflow  output  1  quotient not representable (only case: most-negative / -1).
- div_by_zero  output  1  divisor was 0.

Behaviour:
- Reset: Resetn low asynchronously forces state=IDLE, busy=0, done=0, quotient=0, remainder=0, overflow=0, div_by_zero=0, iteration counter=0. This applies mid-operation too; the in-flight result is discarded.
- States:
  - IDLE: busy=0. On start=1 at an edge: capture |dividend| and |divisor| as WIDTH-bit unsigned (|-2^(WIDTH-1)| = 2^(WIDTH-1), no loss). Capture sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend). Clear the partial remainder, load counter=WIDTH. Next state RUN, or DONE if divisor==0.
  - RUN: one restoring step per cycle. Shift {partial remainder, working quotient} left by 1. Trial = partial remainder − |divisor| in WIDTH+1 bits. If trial ≥ 0, keep the trial and set the quotient LSB to 1; else restore and set it to 0. Decrement counter; after the WIDTH-th step go to FIX.
  - FIX: apply signs. Quotient = sign_q ? −q : q. Remainder = sign_r ? −r : r. overflow = (sign_q==0 && q==2^(WIDTH-1)); quotient bits then read 2^(WIDTH-1) (wrapped). Register all results; next state DONE.
  - DONE: done=1 for exactly one cycle; busy=1 during this cycle. Next state IDLE.
- Latency: start accepted at edge E0 → done high in the cycle after edge E0+WIDTH+1 (WIDTH+2 cycles, 18 for WIDTH=16). Divide-by-zero: done high in the cycle after E0 (1 cycle).
- Divide-by-zero result: quotient=0, remainder=dividend, div_by_zero=1, overflow=0.
- Flags and results hold until the next accepted start. They are cleared on the accepting edge and rewritten at FIX (or on entry to DONE for the zero case).
- start while busy=1 (RUN/FIX/DONE) is ignored and is not queued. start held high continuously re-triggers on the first IDLE edge after DONE.
- Operand inputs may change freely after the accepting edge.
- Zero dividend: quotient=0, remainder=0, no flags.

Decomposition:
- Shared package seq_div_pkg:
  - state enum {IDLE, RUN, FIX, DONE};
  - DEFAULT_WIDTH=16;
  - counter width function clog2(WIDTH+1).
- One natural sub-module, div_step: combinational single restoring step. Inputs: partial remainder, quotient, divisor magnitude. Outputs: next partial remainder and quotient. Instantiated once; the top keeps the FSM, counter and sign fix-up.

Test Plan:
- 100 / 7, start pulsed one cycle → done exactly 18 cycles later; quotient=14, remainder=2, overflow=0, div_by_zero=0; busy high for those 18 cycles.
- −7 / 2, then 7 / −2, then −7 / −2 → (q,r) = (−3,−1), (−3,1), (3,−1) respectively.
- −32768 / −1 → quotient=0x8000, remainder=0, overflow=1. Follow with −32768 / 1 → quotient=−32768, overflow=0.
- 1234 / 0 → done 1 cycle after accept; quotient=0, remainder=1234, div_by_zero=1. Next op 10/3 clears the flag; result q=3, r=1.
- start re-pulsed and operands changed at cycles 3 and 10 of a 500 / 9 operation → ignored; result q=55, r=5; done occurs once.
- Resetn dropped at cycle 8 of an operation, released 2 cycles later → all outputs 0 immediately (asynchronous), no done pulse; a fresh 50 / 5 then yields q=10, r=0 with normal latency.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEFAULT_WIDTH = 16;

    // Bits needed to hold values 0..value-1; used with WIDTH+1 so the counter can hold WIDTH.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift {remainder, quotient} left, trial-subtract the divisor magnitude.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] part_rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH-1:0] next_rem,
    output logic [WIDTH-1:0] next_quo
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    // Trial subtraction; a clear sign bit means the divisor fits and the trial is kept.
    always_comb begin
        shifted_s = {part_rem, quo[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, dmag};
        next_rem  = shifted_s[WIDTH-1:0];
        next_quo  = {quo[WIDTH-2:0], 1'b0};
        if (trial_s[WIDTH] == 1'b0) begin
            next_rem = trial_s[WIDTH-1:0];
            next_quo = {quo[WIDTH-2:0], 1'b1};
        end else begin
            next_rem = shifted_s[WIDTH-1:0];
            next_quo = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider: magnitudes are divided by a shared restoring step, signs applied afterwards.
module seq_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] wq_r;
    logic [WIDTH-1:0] dmag_r;
    logic             sign_q_r;
    logic             sign_r_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             overflow_r;
    logic             dbz_r;

    logic [WIDTH-1:0] dividend_mag_s;
    logic [WIDTH-1:0] divisor_mag_s;
    logic [WIDTH-1:0] step_rem_s;
    logic [WIDTH-1:0] step_quo_s;
    logic [WIDTH-1:0] fix_quo_s;
    logic [WIDTH-1:0] fix_rem_s;
    logic             fix_ovf_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .part_rem (rem_r),
        .quo      (wq_r),
        .dmag     (dmag_r),
        .next_rem (step_rem_s),
        .next_quo (step_quo_s)
    );

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) as unsigned.
    always_comb begin
        dividend_mag_s = dividend;
        divisor_mag_s  = divisor;
        if (dividend[WIDTH-1] == 1'b1) begin
            dividend_mag_s = ZERO - dividend;
        end else begin
            dividend_mag_s = dividend;
        end
        if (divisor[WIDTH-1] == 1'b1) begin
            divisor_mag_s = ZERO - divisor;
        end else begin
            divisor_mag_s = divisor;
        end
    end

    // Sign fix-up; a positive quotient of 2^(WIDTH-1) cannot be represented and wraps.
    always_comb begin
        fix_quo_s = wq_r;
        fix_rem_s = rem_r;
        fix_ovf_s = (sign_q_r == 1'b0) && (wq_r == MOST_NEG);
        if (sign_q_r == 1'b1) begin
            fix_quo_s = ZERO - wq_r;
        end else begin
            fix_quo_s = wq_r;
        end
        if (sign_r_r == 1'b1) begin
            fix_rem_s = ZERO - rem_r;
        end else begin
            fix_rem_s = rem_r;
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            rem_r       <= ZERO;
            wq_r        <= ZERO;
            dmag_r      <= ZERO;
            sign_q_r    <= 1'b0;
            sign_r_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= ZERO;
            remainder_r <= ZERO;
            overflow_r  <= 1'b0;
            dbz_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        busy_r      <= 1'b1;
                        rem_r       <= ZERO;
                        wq_r        <= dividend_mag_s;
                        dmag_r      <= divisor_mag_s;
                        sign_q_r    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r_r    <= dividend[WIDTH-1];
                        cnt_r       <= CW'(WIDTH);
                        quotient_r  <= ZERO;
                        overflow_r  <= 1'b0;
                        if (divisor == ZERO) begin
                            remainder_r <= dividend;
                            dbz_r       <= 1'b1;
                            done_r      <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            remainder_r <= ZERO;
                            dbz_r       <= 1'b0;
                            state_r     <= RUN;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    rem_r <= step_rem_s;
                    wq_r  <= step_quo_s;
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIX: begin
                    quotient_r  <= fix_quo_s;
                    remainder_r <= fix_rem_s;
                    overflow_r  <= fix_ovf_s;
                    done_r      <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign overflow    = overflow_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider.sv
// Randomized and directed bench for seq_divider against a plain-arithmetic division model.
module tb_seq_divider;

    localparam int W = 16;

    logic         Clock;
    logic         Resetn;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         overflow;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Issue one division, wait for done, compare against the arithmetic model.
    task automatic run_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b, input bit ign);
        longint la, lb, qq, rr;
        logic [W-1:0] exp_q, exp_r;
        logic exp_ov, exp_dz;
        int exp_lat, k, busy_lo, dones;
        bit got;
        la = a;
        lb = b;
        if (lb == 0) begin
            qq = 0; rr = la; exp_dz = 1'b1; exp_lat = 0;
        end else begin
            qq = la / lb; rr = la % lb; exp_dz = 1'b0; exp_lat = W + 1;
        end
        exp_ov = (qq > 32767);
        exp_q  = qq[W-1:0];
        exp_r  = rr[W-1:0];

        dividend = a; divisor = b; start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        dividend = 16'($urandom); divisor = 16'($urandom);
        k = 0; got = 1'b0; busy_lo = 0;
        while (k <= 40 && !got) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (!busy) busy_lo++;
                if (ign && (k == 3 || k == 10)) begin
                    start = 1'b1;
                    dividend = 16'($urandom); divisor = 16'($urandom);
                end else begin
                    start = 1'b0;
                end
                @(posedge Clock); #1;
                k++;
            end
        end
        start = 1'b0;
        check_eq("latency", 64'(k), 64'(exp_lat));
        check_eq("busy_during_op", 64'(busy_lo), 64'd0);
        check_eq("busy_at_done", 64'(busy), 64'd1);
        check_eq("quotient", 64'(quotient), 64'(exp_q));
        check_eq("remainder", 64'(remainder), 64'(exp_r));
        check_eq("overflow", 64'(overflow), 64'(exp_ov));
        check_eq("div_by_zero", 64'(div_by_zero), 64'(exp_dz));
        dones = 0;
        repeat (3) begin
            @(posedge Clock); #1;
            if (done) dones++;
        end
        check_eq("single_done", 64'(dones), 64'd0);
        check_eq("busy_after", 64'(busy), 64'd0);
        check_eq("quotient_hold", 64'(quotient), 64'(exp_q));
        check_eq("remainder_hold", 64'(remainder), 64'(exp_r));
    endtask

    initial begin
        int dones;
        logic signed [W-1:0] ra, rb;
        Resetn = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge Clock);
        #1;
        check_eq("reset_outputs", 64'({busy, done, quotient, remainder, overflow, div_by_zero}), 64'd0);
        Resetn = 1'b1;
        @(posedge Clock); #1;

        run_op(16'sd100, 16'sd7, 1'b0);
        run_op(-16'sd7, 16'sd2, 1'b0);
        run_op(16'sd7, -16'sd2, 1'b0);
        run_op(-16'sd7, -16'sd2, 1'b0);
        run_op(-16'sd32768, -16'sd1, 1'b0);
        run_op(-16'sd32768, 16'sd1, 1'b0);
        run_op(16'sd1234, 16'sd0, 1'b0);
        run_op(16'sd10, 16'sd3, 1'b0);
        run_op(16'sd500, 16'sd9, 1'b1);
        run_op(16'sd0, -16'sd5, 1'b0);

        // Abort an operation with an asynchronous reset mid-flight.
        dividend = 16'd100; divisor = 16'd7; start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        repeat (7) @(posedge Clock);
        #1;
        Resetn = 1'b0;
        #1;
        check_eq("async_reset_outputs", 64'({busy, done, quotient, remainder, overflow, div_by_zero}), 64'd0);
        repeat (2) @(posedge Clock);
        #1;
        Resetn = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge Clock); #1;
            if (done || busy) dones++;
        end
        check_eq("no_done_after_reset", 64'(dones), 64'd0);
        run_op(16'sd50, 16'sd5, 1'b0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: begin ra = 16'($urandom_range(0, 200)) - 16'sd100; rb = 16'($urandom_range(0, 20)) - 16'sd10; end
                1: begin ra = 16'($urandom); rb = 16'sd0; end
                2: begin ra = -16'sd32768; rb = ($urandom_range(0, 1) == 0) ? -16'sd1 : 16'($urandom); end
                default: begin ra = 16'($urandom); rb = 16'($urandom); end
            endcase
            run_op(ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
